// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared constants and helpers for the shared-multiplier scheduler
// Contents:
//   DIN0_W, DIN1_W, DOUT_W : default operand/result widths
//   MAX_REQ                : widest requester vector the round-robin helper scans
//   pick_t                 : round-robin pick result {hit, idx}
//   clog2_min1()           : index width, never less than 1
//   rr_pick()              : first valid index at or after ptr, modulo n
package mul_share_pkg;

    localparam int DIN0_W  = 4;
    localparam int DIN1_W  = 2;
    localparam int DOUT_W  = 4;
    localparam int MAX_REQ = 16;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } pick_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scans ptr, ptr+1, ... wrapping at n; the first set bit wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [3:0]         ptr,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!p.hit && valid[j]) begin
                    p.hit = 1'b1;
                    p.idx = 4'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mul_share_sched_mul.sv
// rtl/mul_share_sched_mul.sv - combinational signed multiplier, low DOUT_WIDTH bits of the product
// Ports:
//   din0 : signed operand A, DIN0_WIDTH bits
//   din1 : signed operand B, DIN1_WIDTH bits
//   dout : product wrapped to DOUT_WIDTH bits (no saturation)
module mul_share_sched_mul
    import mul_share_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DIN1_WIDTH = DIN1_W,
    parameter int DOUT_WIDTH = DOUT_W
) (
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic signed [DOUT_WIDTH-1:0] dout
);

    // Wide enough for the full product and for the result, so truncation is the only narrowing.
    localparam int PW = (DIN0_WIDTH + DIN1_WIDTH > DOUT_WIDTH) ? (DIN0_WIDTH + DIN1_WIDTH) : DOUT_WIDTH;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_full;

    assign w_a_ext = PW'(din0);
    assign w_b_ext = PW'(din1);
    assign w_full  = w_a_ext * w_b_ext;
    assign dout    = DOUT_WIDTH'(w_full);

endmodule

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin scheduler sharing one signed multiplier among NUM_REQ requesters
// Ports:
//   ap_clk, ap_rst       : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake, req_ready one-hot or zero
//   req_din0/req_din1    : packed per-requester operands A and B
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id, rsp_dout     : issuing requester index and truncated signed product
//   busy                 : any stage occupied
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DIN1_WIDTH = DIN1_W,
    parameter int DOUT_WIDTH = DOUT_W,
    parameter int ID_W       = clog2_min1(NUM_REQ)
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic                             busy
);

    // Operand stage
    logic                         r_s1_valid;
    logic [ID_W-1:0]              r_s1_id;
    logic signed [DIN0_WIDTH-1:0] r_s1_a;
    logic signed [DIN1_WIDTH-1:0] r_s1_b;

    // Result stage
    logic                         r_rsp_valid;
    logic [ID_W-1:0]              r_rsp_id;
    logic [DOUT_WIDTH-1:0]        r_rsp_dout;

    logic [ID_W-1:0]              r_rr_ptr;

    logic                         w_s2_load;
    logic                         w_s1_adv;
    logic [MAX_REQ-1:0]           w_valid16;
    logic [3:0]                   w_ptr4;
    pick_t                        w_pick;
    logic [ID_W-1:0]              w_gnt;
    logic                         w_accept;
    logic [ID_W-1:0]              w_ptr_nxt;
    logic signed [DIN0_WIDTH-1:0] w_a;
    logic signed [DIN1_WIDTH-1:0] w_b;
    logic signed [DOUT_WIDTH-1:0] w_prod;

    assign w_s2_load = !r_rsp_valid | rsp_ready;
    assign w_s1_adv  = !r_s1_valid | w_s2_load;

    always_comb begin
        w_valid16                = '0;
        w_valid16[NUM_REQ-1:0]   = req_valid;
        w_ptr4                   = '0;
        w_ptr4[ID_W-1:0]         = r_rr_ptr;
        w_pick                   = rr_pick(w_valid16, w_ptr4, NUM_REQ);
        w_gnt                    = ID_W'(w_pick.idx);
        // Readiness comes from the grant and pipeline space only; hit just says a grant exists.
        w_accept                 = w_pick.hit & w_s1_adv & !ap_rst;
        req_ready                = '0;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_a       = req_din0[w_gnt*DIN0_WIDTH +: DIN0_WIDTH];
    assign w_b       = req_din1[w_gnt*DIN1_WIDTH +: DIN1_WIDTH];
    assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : (w_gnt + ID_W'(1));

    mul_share_sched_mul #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_mul (
        .din0 (r_s1_a),
        .din1 (r_s1_b),
        .dout (w_prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_dout  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_id  <= w_gnt;
                    r_s1_a   <= w_a;
                    r_s1_b   <= w_b;
                    r_rr_ptr <= w_ptr_nxt;
                end
            end
            if (w_s2_load) begin
                r_rsp_valid <= r_s1_valid;
                // Bubble into stage 2 leaves the last id/product visible.
                if (r_s1_valid) begin
                    r_rsp_id   <= r_s1_id;
                    r_rsp_dout <= w_prod;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_dout  = r_rsp_dout;
    assign busy      = r_s1_valid | r_rsp_valid;

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - self-checking bench for mul_share_sched
module tb_mul_share_sched;

    localparam int N = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_din0;
    logic [7:0]  req_din1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_dout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mul_share_sched #(
        .NUM_REQ    (4),
        .DIN0_WIDTH (4),
        .DIN1_WIDTH (2),
        .DOUT_WIDTH (4),
        .ID_W       (2)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int prod4(input logic [3:0] a, input logic [1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return (sa * sb) & 15;
    endfunction

    // Reference model: FIFO of accepted operations, at most two in flight.
    // The head is presented once it has been held across at least one edge.
    typedef struct {
        int id;
        int dout;
        int age;
    } item_t;

    item_t q[$];
    int    m_ptr       = 0;
    int    m_last_id   = 0;
    int    m_last_dout = 0;
    bit    m_ok        = 1'b0;

    always @(negedge ap_clk) begin
        int    exp_ready;
        int    gnt;
        int    j;
        bit    hit;
        bit    vis;
        bit    can;
        item_t it;

        vis = (q.size() > 0) && (q[0].age >= 1);
        hit = 1'b0;
        gnt = 0;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!hit && req_valid[j]) begin
                hit = 1'b1;
                gnt = j;
            end
        end
        can       = (q.size() < 2) || (vis && rsp_ready);
        exp_ready = (!ap_rst && hit && can) ? (1 << gnt) : 0;

        if (m_ok || ap_rst) begin
            chk("m_req_ready", int'(req_ready), exp_ready);
        end
        if (m_ok) begin
            chk("m_rsp_valid", int'(rsp_valid), int'(vis));
            chk("m_busy", int'(busy), int'(q.size() > 0));
            chk("m_rsp_id", int'(rsp_id), m_last_id);
            chk("m_rsp_dout", int'(rsp_dout), m_last_dout);
        end

        if (ap_rst) begin
            q.delete();
            m_ptr       = 0;
            m_last_id   = 0;
            m_last_dout = 0;
            m_ok        = 1'b1;
        end else if (m_ok) begin
            if (vis && rsp_ready) begin
                void'(q.pop_front());
            end
            foreach (q[i]) begin
                q[i].age = q[i].age + 1;
            end
            if (exp_ready != 0) begin
                it.id   = gnt;
                it.dout = prod4(req_din0[gnt*4 +: 4], req_din1[gnt*2 +: 2]);
                it.age  = 0;
                q.push_back(it);
                m_ptr = (gnt + 1) % N;
            end
            if ((q.size() > 0) && (q[0].age >= 1)) begin
                m_last_id   = q[0].id;
                m_last_dout = q[0].dout;
            end
        end
    end

    task automatic cyc();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [1:0] b);
        req_valid[i]       = 1'b1;
        req_din0[i*4 +: 4] = a;
        req_din1[i*2 +: 2] = b;
    endtask

    logic [3:0] wa[4]   = '{4'h8, 4'h7, 4'h5, 4'hD};
    logic [1:0] wb[4]   = '{2'b10, 2'b11, 2'b10, 2'b10};
    logic [3:0] wexp[4] = '{4'b0000, 4'b1001, 4'b0110, 4'b0110};
    int         seq[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int         alt[4]  = '{2, 8, 2, 8};

    initial begin
        ap_rst    = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;
        repeat (2) cyc();
        ap_rst = 1'b0;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_dout", int'(rsp_dout), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // Single request from requester 2
        set_req(2, 4'd3, 2'd1);
        #1 chk("t1_ready", int'(req_ready), 4);
        cyc();
        req_valid = '0;
        #1 chk("t1_lat_valid", int'(rsp_valid), 0);
        cyc();
        #1;
        chk("t1_valid", int'(rsp_valid), 1);
        chk("t1_id", int'(rsp_id), 2);
        chk("t1_dout", int'(rsp_dout), 3);

        // Signed wrap vectors from requester 0, back to back
        for (int i = 0; i < 4; i++) begin
            set_req(0, wa[i], wb[i]);
            cyc();
            if (i >= 1) begin
                #1;
                chk("t2_dout", int'(rsp_dout), int'(wexp[i-1]));
                chk("t2_id", int'(rsp_id), 0);
            end
        end
        req_valid = '0;
        cyc();
        #1 chk("t2_dout_last", int'(rsp_dout), int'(wexp[3]));

        // Move the pointer to 0, then all requesters valid
        req_valid = 4'b1000;
        cyc();
        for (int i = 0; i < N; i++) begin
            set_req(i, 4'(i + 1), 2'd1);
        end
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 8) begin
                req_valid = '0;
            end
            if (k >= 2) begin
                #1;
                chk("t3_valid", int'(rsp_valid), 1);
                chk("t3_id", int'(rsp_id), seq[k-2]);
                chk("t3_dout", int'(rsp_dout), seq[k-2] + 1);
            end
        end
        cyc();

        // Stall with all requesters valid
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        #1;
        chk("t4_ready_full", int'(req_ready), 0);
        chk("t4_id_held", int'(rsp_id), 0);
        chk("t4_dout_held", int'(rsp_dout), 1);
        cyc();
        #1;
        chk("t4_id_stable", int'(rsp_id), 0);
        chk("t4_dout_stable", int'(rsp_dout), 1);
        chk("t4_ready_stall", int'(req_ready), 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        #1;
        chk("t4_rel_valid", int'(rsp_valid), 1);
        chk("t4_rel_id", int'(rsp_id), 1);
        chk("t4_rel_dout", int'(rsp_dout), 2);
        cyc();
        #1 chk("t4_drained", int'(rsp_valid), 0);

        // Only requesters 1 and 3 valid, pointer starting at 0
        req_valid = 4'b1000;
        cyc();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_alt", int'(req_ready), alt[i]);
            cyc();
        end
        req_valid = '0;

        // Reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        cyc();
        cyc();
        #1;
        chk("t6_busy_full", int'(busy), 1);
        chk("t6_ready_full", int'(req_ready), 0);
        ap_rst = 1'b1;
        #1 chk("t6_ready_rst", int'(req_ready), 0);
        cyc();
        ap_rst    = 1'b0;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        #1;
        chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_gnt", int'(req_ready), 2);
        cyc();
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
